// File: rtl/mips_pkg.sv
// Shared types and constants for the memory dump reader and its byte assembler.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/word_assembler.sv
// Collects four byte lanes into a little-endian 32-bit word; lane k lands in bits [8k+7:8k].
module word_assembler
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear_i,
  input  logic        capture_i,
  input  logic [1:0]  idx_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o
);

  logic [31:0] word_q, word_d;

  always_comb begin
    word_d = word_q;
    if (clear_i) begin
      word_d = '0;
    end else begin
      for (int i = 0; i < BYTES_PER_WORD; i++) begin
        if (capture_i && (idx_i == 2'(i))) begin
          word_d[8*i +: 8] = byte_i;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      word_q <= '0;
    end else begin
      word_q <= word_d;
    end
  end

  assign word_o = word_q;

endmodule

// File: rtl/mem_dump_reader.sv
// Walks a byte-wide memory from a word-aligned base, assembling and streaming
// little-endian 32-bit words to a consumer, then pulses done.
module mem_dump_reader
  import mips_pkg::*;
#(
  parameter int CNT_W = 16
)
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic [CNT_W-1:0] word_count,
  output logic [31:0]      mem_addr,
  input  logic [7:0]       mem_rdata,
  output logic [31:0]      out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy,
  output logic             done,
  output state_t           dbg_state
);

  // Output handshake: a word transfers on any rising edge where out_valid and
  // out_ready are both high; while out_valid is high and out_ready low,
  // out_data and out_last hold their values.

  state_t           state_q, state_d;
  logic [31:0]      ptr_q, ptr_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [1:0]       idx_q, idx_d;
  logic             asm_clear;
  logic             asm_capture;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      rem_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    rem_d       = rem_q;
    idx_d       = idx_q;
    asm_clear   = 1'b0;
    asm_capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          ptr_d     = {base_addr[31:2], 2'b00};
          rem_d     = word_count;
          idx_d     = '0;
          asm_clear = 1'b1;
          state_d   = (word_count != '0) ? FETCH : DONE;
        end
      end
      FETCH: begin
        asm_capture = 1'b1;
        idx_d       = idx_q + 2'd1;
        if (idx_q == 2'(BYTES_PER_WORD - 1)) begin
          state_d = SEND;
        end
      end
      SEND: begin
        if (out_ready) begin
          // Pointer wraps naturally at 32 bits.
          ptr_d   = ptr_q + 32'(BYTES_PER_WORD);
          rem_d   = rem_q - CNT_W'(1);
          state_d = (rem_q == CNT_W'(1)) ? DONE : FETCH;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign mem_addr  = (state_q == FETCH) ? (ptr_q + {30'd0, idx_q}) : ptr_q;
  assign out_valid = (state_q == SEND);
  assign out_last  = (state_q == SEND) && (rem_q == CNT_W'(1));
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign dbg_state = state_q;

  word_assembler u_asm (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (asm_clear),
    .capture_i (asm_capture),
    .idx_i     (idx_q),
    .byte_i    (mem_rdata),
    .word_o    (out_data)
  );

endmodule

// File: doc/mem_dump_reader.md
MEM_DUMP_READER -- requirements
Module: mem_dump_reader

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the word-count field.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  one-cycle request to begin a dump; sampled only in IDLE.
REQ-005 SHALL have port base_addr  input  32  byte address of the first word; latched on accepted start.
REQ-006 SHALL have port word_count  input  CNT_W  number of 32-bit words to dump; latched on accepted start.
REQ-007 SHALL have port mem_addr  output  32  byte address presented to a byte-wide memory.
REQ-008 SHALL have port mem_rdata  input  8  byte at mem_addr; combinational read, valid in the same cycle.
REQ-009 SHALL have port out_data  output  32  assembled little-endian word.
REQ-010 SHALL have port out_valid  output  1  out_data/out_last valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts the word when high together with out_valid.
REQ-012 SHALL have port out_last  output  1  high with the final word of a dump.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-014 SHALL have port done  output  1  one-cycle pulse after the dump completes.

Function
REQ-015 SHALL implement FSM states IDLE, FETCH, SEND, DONE.
REQ-016 IDLE: on start, latch {base_addr[31:2],2'b00} as the word pointer and word_count as remaining; go to FETCH if word_count!=0, else go to DONE.
REQ-017 FETCH: SHALL take exactly 4 cycles, byte index k=0..3; mem_addr=pointer+k; mem_rdata captured into out_data[8k+7:8k]; after k=3 go to SEND.
REQ-018 SEND: out_valid=1; out_data and out_last SHALL stay stable until out_valid&&out_ready.
REQ-019 On a SEND handshake: pointer+=4 (mod 2^32); remaining-=1; if remaining was 1 go to DONE, else go to FETCH.
REQ-020 out_last SHALL be 1 in SEND exactly when remaining==1.
REQ-021 DONE: done=1 for one cycle, then IDLE; no word SHALL be emitted for word_count=0.
REQ-022 start SHALL be ignored outside IDLE (no restart, no relatch).
REQ-023 Pointer arithmetic SHALL wrap: pointer 32'hFFFF_FFFC + 4 = 32'h0000_0000 with no error.
REQ-024 mem_addr SHALL equal the word pointer when not in FETCH; its value is don't-care to memory there.
REQ-025 Throughput: with out_ready held high, one word per 5 cycles; first out_valid 5 cycles after the start cycle.
REQ-026 base_addr[1:0] SHALL be ignored (address forced word-aligned).

Reset
REQ-027 On reset (any state, including mid-FETCH or SEND with out_valid high), the next state SHALL be IDLE with out_valid=0, out_last=0, done=0, busy=0, out_data=0, mem_addr=0, byte index=0, remaining=0.
REQ-028 A start asserted in the same cycle as reset SHALL be ignored.

Structure
REQ-029 The state enum and constant BYTES_PER_WORD=4 SHALL live in the shared package mips_pkg.
REQ-030 Byte-lane capture (index k, 8-bit in, 32-bit out, clear) SHALL be one sub-module, word_assembler; everything else stays in mem_dump_reader.

Verification
REQ-031 Memory bytes 0..7 = 0x78,0x56,0x34,0x12,0xEF,0xBE,0xAD,0xDE; start with base 0, count 2, ready high -> words 0x12345678 then 0xDEADBEEF (last=1), done pulse 1 cycle after the second handshake.
REQ-032 Count 0 -> no out_valid, busy for exactly 1 cycle (DONE), done pulse 1 cycle after start.
REQ-033 Count 3, out_ready low for 7 cycles on word 2 -> out_data/out_last stable throughout; 3 words delivered in order, no duplicates.
REQ-034 base 32'hFFFF_FFFD, count 2 -> mem_addr sequence FFFFFFFC..FFFFFFFF then 00000000..00000003.
REQ-035 Reset asserted in SEND of word 1 of 4, then a fresh start with count 1 -> all outputs 0 after reset, single word with out_last=1, then done.
REQ-036 start pulsed again mid-dump with a different base_addr -> ignored; original sequence unchanged.
